// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the write-back port arbiter and its result buffer.
package wb_port_arbiter_pkg;

   localparam int REG_FIELD            = 5;
   localparam int STARVE_LIMIT_DEFAULT = 4;
   // Entry data field is sized for the widest supported WIDTH; users take [WIDTH-1:0].
   localparam int MAX_WIDTH            = 64;

   typedef struct packed {
      logic                 valid;
      logic [REG_FIELD-1:0] rd;
      logic [MAX_WIDTH-1:0] data;
   } wb_entry_t;

   function automatic logic wr_allowed(input logic en, input logic [REG_FIELD-1:0] rd);
      return en && (rd != '0);
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Long-latency result buffer: circular storage with per-entry write-after-write kill.
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  wb_entry_t            push_entry,
   input  logic                 pop,
   input  logic                 kill,
   input  logic [REG_FIELD-1:0] kill_rd,
   output wb_entry_t            head,
   output logic                 empty,
   output logic                 full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Kill, then pop, then push: a push landing in the slot just freed by a pop
   // (full buffer) or sharing the kill rd must survive as the youngest write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (kill && mem[i].valid && mem[i].rd == kill_rd) mem[i].valid <= 1'b0;
         if (pop) begin
            mem[rd_ptr].valid <= 1'b0;
            rd_ptr            <= next_ptr(rd_ptr);
         end
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: pipeline writes win, buffered mul/div results drain in idle slots.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     reg_wr_data_MEMWB,
   input  logic [REG_FIELD-1:0] rd_MEMWB,
   input  logic                 reg_wr_en_MEMWB,
   input  logic [WIDTH-1:0]     md_data_MDWB,
   input  logic [REG_FIELD-1:0] md_rd_MDWB,
   input  logic                 md_valid_MDWB,
   output logic                 md_ready_WBMD,
   output logic [WIDTH-1:0]     reg_wr_data_WBID,
   output logic [REG_FIELD-1:0] rd_WBID,
   output logic                 reg_wr_en_WBID,
   output logic                 stall_WB
);

   wb_entry_t push_entry, head;
   logic      empty, full, push, pop, kill, head_live;
   logic      unused_data;

   // Any pipeline request owns the port, even one to x0 whose enable is then dropped.
   assign pop       = !reg_wr_en_MEMWB && !empty;
   assign kill      = wr_allowed(reg_wr_en_MEMWB, rd_MEMWB);
   assign push      = md_valid_MDWB && md_ready_WBMD && (md_rd_MDWB != '0);
   assign head_live = !empty && head.valid;
   assign md_ready_WBMD = !full;
   assign unused_data   = ^head.data;

   always_comb begin
      push_entry                 = '0;
      push_entry.valid           = 1'b1;
      push_entry.rd              = md_rd_MDWB;
      push_entry.data[WIDTH-1:0] = md_data_MDWB;
   end

   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill       (kill),
      .kill_rd    (rd_MEMWB),
      .head       (head),
      .empty      (empty),
      .full       (full)
   );

   always_comb begin
      reg_wr_data_WBID = '0;
      rd_WBID          = '0;
      reg_wr_en_WBID   = 1'b0;
      if (!reset) begin
         if (reg_wr_en_MEMWB) begin
            reg_wr_data_WBID = reg_wr_data_MEMWB;
            rd_WBID          = rd_MEMWB;
            reg_wr_en_WBID   = wr_allowed(1'b1, rd_MEMWB);
         end else if (head_live) begin
            reg_wr_data_WBID = head.data[WIDTH-1:0];
            rd_WBID          = head.rd;
            reg_wr_en_WBID   = 1'b1;
         end
      end
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] starve_cnt;
   logic            stall_q, lose;

   assign lose = reg_wr_en_MEMWB && head_live;

   // The limit-th lost cycle raises stall for the following cycle only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else begin
         if (pop || stall_q) starve_cnt <= '0;
         else if (lose)      starve_cnt <= starve_cnt + SC_W'(1);
         stall_q <= !pop && !stall_q && lose && (starve_cnt == SC_W'(STARVE_LIMIT - 1));
      end
   end

   assign stall_WB = stall_q;
`else
   localparam int unused_starve_limit = STARVE_LIMIT;
   assign stall_WB = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_wb_port_arbiter;

   localparam int W  = 32;
   localparam int D  = 2;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  wdata, md_data, o_data;
   logic [4:0]    rd, md_rd, o_rd;
   logic          en, md_valid, md_ready, o_en, stall;

   int checks = 0;
   int passes = 0;
   logic [W-1:0] dut_rf [32];
   logic [W-1:0] mdl_rf [32];

   typedef struct {
      bit         v;
      logic [4:0] rd;
      logic [W-1:0] d;
   } ment_t;

   wb_port_arbiter #(.WIDTH(W), .DEPTH(D), .STARVE_LIMIT(SL)) dut (
      .clk               (clk),
      .reset             (rst),
      .reg_wr_data_MEMWB (wdata),
      .rd_MEMWB          (rd),
      .reg_wr_en_MEMWB   (en),
      .md_data_MDWB      (md_data),
      .md_rd_MDWB        (md_rd),
      .md_valid_MDWB     (md_valid),
      .md_ready_WBMD     (md_ready),
      .reg_wr_data_WBID  (o_data),
      .rd_WBID           (o_rd),
      .reg_wr_en_WBID    (o_en),
      .stall_WB          (stall)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (!rst && o_en) dut_rf[o_rd] = o_data;

   task automatic idle();
      en = 0; rd = 0; wdata = 0; md_valid = 0; md_rd = 0; md_data = 0;
   endtask

   task automatic apply_reset();
      rst = 1; idle();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      for (int i = 0; i < 32; i++) begin dut_rf[i] = 0; mdl_rf[i] = 0; end
   endtask

   task automatic test_reset();
      rst = 1; idle();
      en = 1; rd = 3; wdata = 32'h33;
      @(negedge clk); #1;
      checks++; if (o_en !== 1'b0) $display("FAIL reset_en got %b want 0", o_en); else passes++;
      checks++; if (md_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", md_ready); else passes++;
      checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passes++;
      apply_reset();
   endtask

   task automatic test_pipe_only();
      @(negedge clk); en = 1; rd = 5; wdata = 32'h11; #1;
      checks++; if (o_rd !== 5'd5) $display("FAIL pipe_rd got %0d want 5", o_rd); else passes++;
      checks++; if (o_data !== 32'h11) $display("FAIL pipe_data got %h want 11", o_data); else passes++;
      checks++; if (o_en !== 1'b1) $display("FAIL pipe_en got %b want 1", o_en); else passes++;
      @(negedge clk); en = 1; rd = 0; wdata = 32'h99; #1;
      checks++; if (o_en !== 1'b0) $display("FAIL pipe_x0_en got %b want 0", o_en); else passes++;
      @(negedge clk); idle(); #1;
      checks++; if ({o_en, o_rd, o_data} !== '0) $display("FAIL idle_zero got %b/%0d/%h want 0/0/0", o_en, o_rd, o_data); else passes++;
   endtask

   task automatic test_buffered();
      apply_reset();
      md_valid = 1; md_rd = 7; md_data = 32'hAA; #1;
      checks++; if (o_en !== 1'b0) $display("FAIL buf_push_en got %b want 0", o_en); else passes++;
      @(negedge clk); idle(); #1;
      checks++; if (o_en !== 1'b1 || o_rd !== 5'd7 || o_data !== 32'hAA)
         $display("FAIL buf_pop got %b/%0d/%h want 1/7/aa", o_en, o_rd, o_data); else passes++;
      @(negedge clk); #1;
      checks++; if (o_en !== 1'b0 || md_ready !== 1'b1) $display("FAIL buf_empty got en %b rdy %b want 0/1", o_en, md_ready); else passes++;
      // x0 result is accepted but never written
      md_valid = 1; md_rd = 0; md_data = 32'h77;
      @(negedge clk); idle(); #1;
      checks++; if (o_en !== 1'b0) $display("FAIL md_x0_en got %b want 0", o_en); else passes++;
   endtask

   task automatic test_full();
      apply_reset();
      en = 1; rd = 1; wdata = 1; md_valid = 1; md_rd = 10; md_data = 32'hA0;
      @(negedge clk); en = 1; rd = 2; wdata = 2; md_rd = 11; md_data = 32'hB0; #1;
      checks++; if (md_ready !== 1'b1) $display("FAIL full_rdy1 got %b want 1", md_ready); else passes++;
      @(negedge clk); en = 1; rd = 3; wdata = 3; md_rd = 12; md_data = 32'hC0; #1;
      checks++; if (md_ready !== 1'b0) $display("FAIL full_rdy0 got %b want 0", md_ready); else passes++;
      checks++; if (o_rd !== 5'd3 || o_en !== 1'b1) $display("FAIL full_pipe got %0d/%b want 3/1", o_rd, o_en); else passes++;
      @(negedge clk); en = 0; #1;
      checks++; if (md_ready !== 1'b0) $display("FAIL full_hold_rdy got %b want 0", md_ready); else passes++;
      checks++; if (o_rd !== 5'd10 || o_data !== 32'hA0 || o_en !== 1'b1) $display("FAIL full_pop1 got %0d/%h want 10/a0", o_rd, o_data); else passes++;
      @(negedge clk); #1;
      checks++; if (md_ready !== 1'b1) $display("FAIL full_rdy_again got %b want 1", md_ready); else passes++;
      checks++; if (o_rd !== 5'd11 || o_data !== 32'hB0) $display("FAIL full_pop2 got %0d/%h want 11/b0", o_rd, o_data); else passes++;
      @(negedge clk); md_valid = 0; #1;
      checks++; if (o_rd !== 5'd12 || o_data !== 32'hC0 || o_en !== 1'b1) $display("FAIL full_pop3 got %0d/%h want 12/c0", o_rd, o_data); else passes++;
      @(negedge clk); #1;
      checks++; if (o_en !== 1'b0) $display("FAIL full_drained got %b want 0", o_en); else passes++;
   endtask

   task automatic test_waw_kill();
      apply_reset();
      en = 1; rd = 4; wdata = 4; md_valid = 1; md_rd = 9; md_data = 1;
      @(negedge clk); md_valid = 0; en = 1; rd = 9; wdata = 2; #1;
      checks++; if (o_rd !== 5'd9 || o_data !== 32'h2 || o_en !== 1'b1) $display("FAIL waw_pipe got %0d/%h/%b want 9/2/1", o_rd, o_data, o_en); else passes++;
      @(negedge clk); idle(); #1;
      checks++; if (o_en !== 1'b0) $display("FAIL waw_killed_pop got %b want 0", o_en); else passes++;
      @(negedge clk); #1;
      checks++; if (md_ready !== 1'b1) $display("FAIL waw_slot_freed got %b want 1", md_ready); else passes++;
      checks++; if (dut_rf[9] !== 32'h2) $display("FAIL waw_final_x9 got %h want 2", dut_rf[9]); else passes++;
      // same-cycle push and pipeline write to the same rd: the push is younger and survives
      en = 1; rd = 8; wdata = 5; md_valid = 1; md_rd = 8; md_data = 6;
      @(negedge clk); idle(); #1;
      checks++; if (o_rd !== 5'd8 || o_data !== 32'h6 || o_en !== 1'b1) $display("FAIL waw_younger got %0d/%h/%b want 8/6/1", o_rd, o_data, o_en); else passes++;
   endtask

`ifdef WB_STARVE_GUARD_EN
   task automatic test_starve();
      apply_reset();
      en = 1; rd = 1; wdata = 1; md_valid = 1; md_rd = 20; md_data = 32'h55;
      @(negedge clk); md_valid = 0;
      for (int i = 0; i < SL; i++) begin
         en = 1; rd = 5'(2 + i); wdata = i; #1;
         checks++; if (stall !== 1'b0) $display("FAIL starve_early cyc %0d got %b want 0", i, stall); else passes++;
         @(negedge clk);
      end
      en = 0; #1;
      checks++; if (stall !== 1'b1) $display("FAIL starve_stall got %b want 1", stall); else passes++;
      checks++; if (o_rd !== 5'd20 || o_data !== 32'h55 || o_en !== 1'b1) $display("FAIL starve_head got %0d/%h want 20/55", o_rd, o_data); else passes++;
      @(negedge clk); #1;
      checks++; if (stall !== 1'b0) $display("FAIL starve_one_cycle got %b want 0", stall); else passes++;
   endtask
`endif

   task automatic test_reset_mid();
      apply_reset();
      en = 1; rd = 1; wdata = 1; md_valid = 1; md_rd = 21; md_data = 21;
      @(negedge clk); en = 1; rd = 2; md_rd = 22; md_data = 22;
      @(negedge clk); idle(); en = 1; rd = 3; #1;
      checks++; if (md_ready !== 1'b0) $display("FAIL mid_full got %b want 0", md_ready); else passes++;
      #1 en = 0; rst = 1; #1;
      checks++; if (md_ready !== 1'b1 || o_en !== 1'b0) $display("FAIL mid_reset got rdy %b en %b want 1/0", md_ready, o_en); else passes++;
      @(negedge clk); rst = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (o_en !== 1'b0) $display("FAIL mid_stale cyc %0d got %b want 0", i, o_en); else passes++;
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      ment_t      q[$];
      logic       e_en, e_rdy;
      logic [4:0] e_rd;
      logic [W-1:0] e_d;
      apply_reset();
      for (int c = 0; c < 410; c++) begin
         if (c < 400) begin
            en = ($urandom_range(0, 9) < 6);
`ifdef WB_STARVE_GUARD_EN
            if (stall) en = 0;
`endif
            rd = 5'($urandom_range(0, 3)); wdata = $urandom;
            md_valid = 1'($urandom_range(0, 1)); md_rd = 5'($urandom_range(0, 3)); md_data = $urandom;
         end else idle();
         #1;
         e_rdy = (q.size() < D);
         e_en = 0; e_rd = 0; e_d = 0;
         if (en) begin
            e_en = (rd != 0); e_rd = rd; e_d = wdata;
         end else if (q.size() > 0 && q[0].v) begin
            e_en = 1; e_rd = q[0].rd; e_d = q[0].d;
         end
         checks++; if (md_ready !== e_rdy) $display("FAIL rnd_ready cyc %0d got %b want %b", c, md_ready, e_rdy); else passes++;
         checks++; if (o_en !== e_en) $display("FAIL rnd_en cyc %0d got %b want %b", c, o_en, e_en); else passes++;
         checks++; if (o_rd !== e_rd) $display("FAIL rnd_rd cyc %0d got %0d want %0d", c, o_rd, e_rd); else passes++;
         checks++; if (o_data !== e_d) $display("FAIL rnd_data cyc %0d got %h want %h", c, o_data, e_d); else passes++;
`ifndef WB_STARVE_GUARD_EN
         checks++; if (stall !== 1'b0) $display("FAIL rnd_stall cyc %0d got %b want 0", c, stall); else passes++;
`endif
         if (e_en) mdl_rf[e_rd] = e_d;
         if (en && rd != 0) foreach (q[i]) if (q[i].rd == rd) q[i].v = 0;
         if (!en && q.size() > 0) void'(q.pop_front());
         if (md_valid && e_rdy && md_rd != 0) q.push_back('{1'b1, md_rd, md_data});
         @(negedge clk);
      end
      for (int r = 1; r < 4; r++) begin
         checks++; if (dut_rf[r] !== mdl_rf[r]) $display("FAIL rnd_rf x%0d got %h want %h", r, dut_rf[r], mdl_rf[r]); else passes++;
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin dut_rf[i] = 0; mdl_rf[i] = 0; end
      test_reset();
      test_pipe_only();
      test_buffered();
      test_full();
      test_waw_kill();
`ifdef WB_STARVE_GUARD_EN
      test_starve();
`endif
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
